// File: rtl/cmp_bist.sv
// rtl/cmp_bist.sv - exhaustive stimulus generator and self-checker for an equality comparator
module cmp_bist #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic             AyB,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2*WIDTH:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int IW = 2 * WIDTH;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW:0]      err_q, err_d;
    logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
    logic             pass_q, pass_d;

    logic [WIDTH-1:0] vec_a, vec_b;
    logic             mismatch;

    assign vec_a    = idx_q[IW-1:WIDTH];
    assign vec_b    = idx_q[WIDTH-1:0];
    assign mismatch = (AyB != (vec_a == vec_b));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_APPLY;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fa_d    = '0;
                    fb_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_d = '0;
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        fa_d = vec_a;
                        fb_d = vec_b;
                    end
                end
                // pass must already be valid while done is high
                if (idx_q == '1) begin
                    state_d = S_DONE;
                    pass_d  = (err_q == '0) && !mismatch;
                end else begin
                    state_d = S_APPLY;
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        A         = '0;
        B         = '0;
        if (state_q == S_APPLY || state_q == S_CHECK) begin
            A = vec_a;
            B = vec_b;
        end
        pass      = pass_q;
        err_count = err_q;
        fail_a    = fa_q;
        fail_b    = fb_q;
    end

endmodule
